// File: rtl/mx_pkg.sv
// Shared MX format defaults and negate-mode encodings.
package mx_pkg;

  localparam int unsigned MX_BLOCK_SIZE        = 32;
  localparam int unsigned MXINT8_ELEMENT_WIDTH = 8;
  localparam int unsigned MX_SCALE_WIDTH       = 8;

  localparam logic MX_NEG_INT = 1'b0;
  localparam logic MX_NEG_FP  = 1'b1;

endpackage

// File: rtl/mx_negate_lane.sv
// Single-element MX negate: saturating two's complement (INT) or sign flip (FP).
module mx_negate_lane
  import mx_pkg::*;
#(
  parameter int unsigned ELEM_WIDTH = MXINT8_ELEMENT_WIDTH
) (
  input  logic [ELEM_WIDTH-1:0] elem_i,
  input  logic                  mode_i,
  output logic [ELEM_WIDTH-1:0] elem_o,
  output logic                  sat_o
);

  localparam logic [ELEM_WIDTH-1:0] MinVal = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

  always_comb begin
    elem_o = (~elem_i) + 1'b1;
    sat_o  = 1'b0;
    if (mode_i == MX_NEG_FP) begin
      elem_o = elem_i ^ MinVal;
    end else if (elem_i == MinVal) begin
      // -MIN is unrepresentable; clamp to MAX and flag it.
      elem_o = ~MinVal;
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/mx_negate_stream.sv
// Streaming MX block negate: per-beat lane negation, block framing and saturation count,
// one registered output stage with valid/ready handshake.
module mx_negate_stream
  import mx_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE  = MX_BLOCK_SIZE,
  parameter int unsigned ELEM_WIDTH  = MXINT8_ELEMENT_WIDTH,
  parameter int unsigned SCALE_WIDTH = MX_SCALE_WIDTH,
  parameter int unsigned LANES       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_valid,
  output logic                                 o_in_ready,
  input  logic                                 i_mode,
  input  logic [SCALE_WIDTH-1:0]               i_scale,
  input  logic [0:LANES-1][ELEM_WIDTH-1:0]     i_elements,
  output logic                                 o_valid,
  input  logic                                 i_out_ready,
  output logic [SCALE_WIDTH-1:0]               o_scale,
  output logic [0:LANES-1][ELEM_WIDTH-1:0]     o_elements,
  output logic                                 o_first,
  output logic                                 o_last,
  output logic [$clog2(BLOCK_SIZE+1)-1:0]      o_sat_count
);

  localparam int unsigned Beats = BLOCK_SIZE / LANES;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned SatW  = $clog2(BLOCK_SIZE + 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  logic [BeatW-1:0]                   in_beat_q, in_beat_d;
  logic                               blk_mode_q, blk_mode_d;
  logic [SCALE_WIDTH-1:0]             blk_scale_q, blk_scale_d;
  logic [SatW-1:0]                    acc_q, acc_d;
  logic                               valid_q, valid_d;
  logic [0:LANES-1][ELEM_WIDTH-1:0]   elems_q, elems_d;
  logic                               first_q, first_d;
  logic                               last_q, last_d;

  logic                               accept;
  logic                               beat_first;
  logic                               beat_last;
  logic                               eff_mode;
  logic [SCALE_WIDTH-1:0]             eff_scale;
  logic [0:LANES-1][ELEM_WIDTH-1:0]   neg_elems;
  logic [LANES-1:0]                   lane_sat;
  logic [SatW-1:0]                    beat_sat;
  logic [SatW-1:0]                    acc_sum;

  assign o_in_ready = ~rst & (~valid_q | i_out_ready);
  assign accept     = i_valid & o_in_ready;
  assign beat_first = (in_beat_q == '0);
  assign beat_last  = (in_beat_q == LastBeat);

  // Beat 0 uses the live mode/scale; later beats use the values latched on beat 0.
  assign eff_mode  = beat_first ? i_mode  : blk_mode_q;
  assign eff_scale = beat_first ? i_scale : blk_scale_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mx_negate_lane #(
      .ELEM_WIDTH(ELEM_WIDTH)
    ) u_lane (
      .elem_i(i_elements[l]),
      .mode_i(eff_mode),
      .elem_o(neg_elems[l]),
      .sat_o (lane_sat[l])
    );
  end

  always_comb begin
    beat_sat = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sat = beat_sat + SatW'(lane_sat[l]);
    end
    acc_sum = (beat_first ? '0 : acc_q) + beat_sat;
  end

  always_comb begin
    in_beat_d   = in_beat_q;
    blk_mode_d  = blk_mode_q;
    blk_scale_d = blk_scale_q;
    acc_d       = acc_q;
    valid_d     = valid_q;
    elems_d     = elems_q;
    first_d     = first_q;
    last_d      = last_q;
    if (accept) begin
      in_beat_d   = beat_last ? '0 : in_beat_q + 1'b1;
      blk_mode_d  = eff_mode;
      blk_scale_d = eff_scale;
      acc_d       = acc_sum;
      valid_d     = 1'b1;
      elems_d     = neg_elems;
      first_d     = beat_first;
      last_d      = beat_last;
    end else if (i_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_beat_q   <= '0;
      blk_mode_q  <= MX_NEG_INT;
      blk_scale_q <= '0;
      acc_q       <= '0;
      valid_q     <= 1'b0;
      elems_q     <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      in_beat_q   <= in_beat_d;
      blk_mode_q  <= blk_mode_d;
      blk_scale_q <= blk_scale_d;
      acc_q       <= acc_d;
      valid_q     <= valid_d;
      elems_q     <= elems_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  // Scale and accumulator only change on an accepted beat, exactly when the output
  // stage loads, so they double as the registered outputs.
  assign o_valid     = valid_q;
  assign o_elements  = elems_q;
  assign o_first     = first_q;
  assign o_last      = last_q;
  assign o_scale     = blk_scale_q;
  assign o_sat_count = acc_q;

endmodule

// File: tb/tb_mx_negate_stream.sv
// Scoreboard bench for mx_negate_stream: driver pushes expected beats, monitor pops and compares.
module tb_mx_negate_stream;

  localparam int unsigned Lanes = 4;
  localparam int unsigned Beats = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_valid;
  logic                   o_in_ready;
  logic                   i_mode;
  logic [7:0]             i_scale;
  logic [0:Lanes-1][7:0]  i_elements;
  logic                   o_valid;
  logic                   i_out_ready;
  logic [7:0]             o_scale;
  logic [0:Lanes-1][7:0]  o_elements;
  logic                   o_first;
  logic                   o_last;
  logic [5:0]             o_sat_count;

  typedef struct {
    logic [31:0] elems;
    logic [7:0]  scale;
    bit          first;
    bit          last;
    int          sat;
    bit          strict;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  mx_negate_stream dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_in_ready (o_in_ready),
    .i_mode     (i_mode),
    .i_scale    (i_scale),
    .i_elements (i_elements),
    .o_valid    (o_valid),
    .i_out_ready(i_out_ready),
    .o_scale    (o_scale),
    .o_elements (o_elements),
    .o_first    (o_first),
    .o_last     (o_last),
    .o_sat_count(o_sat_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compare whatever the DUT presents against the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected none", o_elements);
      end else begin
        exp_t e;
        e = sb[0];
        chk("elements", o_elements, e.elems);
        chk("scale", {24'h0, o_scale}, {24'h0, e.scale});
        chk("first", {31'h0, o_first}, {31'h0, e.first});
        chk("last", {31'h0, o_last}, {31'h0, e.last});
        if (e.last) chk("sat_count", {26'h0, o_sat_count}, e.sat);
        if (i_out_ready) begin
          if (e.strict) chk("latency", cyc, e.cyc + 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] ein, input logic m, input logic [7:0] s,
                           input logic [31:0] eexp, input logic [7:0] sexp, input bit first,
                           input bit last, input int sat, input bit strict);
    exp_t e;
    bit   accepted = 0;
    i_valid    = 1'b1;
    i_elements = ein;
    i_mode     = m;
    i_scale    = s;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (o_in_ready) begin
        e.elems  = eexp;
        e.scale  = sexp;
        e.first  = first;
        e.last   = last;
        e.sat    = sat;
        e.strict = strict;
        e.cyc    = cyc;
        sb.push_back(e);
        accepted = 1;
        break;
      end
    end
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [31:0] ein, input logic [31:0] eexp, input logic m0,
                            input logic mr, input logic [7:0] s0, input logic [7:0] sr,
                            input logic [7:0] sexp, input int sat, input int nbeats,
                            input int stall_at, input bit strict);
    for (int b = 0; b < nbeats; b++) begin
      if (b == stall_at) begin
        i_valid    = 1'b1;
        i_elements = ein;
        i_mode     = mr;
        i_scale    = sr;
        i_out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", {31'h0, o_in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        i_out_ready = 1'b1;
      end
      send_beat(ein, (b == 0) ? m0 : mr, (b == 0) ? s0 : sr, eexp, sexp,
                b == 0, b == Beats - 1, sat, strict);
    end
  endtask

  initial begin
    int start;
    rst         = 1'b1;
    i_valid     = 1'b0;
    i_mode      = 1'b0;
    i_scale     = 8'h00;
    i_elements  = '0;
    i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'h0, o_valid}, 32'd0);
    chk("rst_in_ready", {31'h0, o_in_ready}, 32'd0);
    chk("rst_elements", o_elements, 32'h0);
    chk("rst_sat", {26'h0, o_sat_count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", {31'h0, o_in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Two back-to-back blocks (INT then FP) with no idle cycles.
    start = cyc;
    send_block({8'h01, 8'h7F, 8'h00, 8'h80}, {8'hFF, 8'h81, 8'h00, 8'h7F},
               1'b0, 1'b0, 8'h20, 8'h20, 8'h20, 8, Beats, -1, 1'b1);
    send_block({8'h00, 8'h3C, 8'hBC, 8'h7F}, {8'h80, 8'hBC, 8'h3C, 8'hFF},
               1'b1, 1'b1, 8'h7F, 8'h7F, 8'h7F, 0, Beats, -1, 1'b1);
    chk("no_bubble", cyc - start, 32'd16);
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Mode and scale must be taken from beat 0 only.
    send_block({8'h01, 8'h80, 8'h7F, 8'h40}, {8'hFF, 8'h7F, 8'h81, 8'hC0},
               1'b0, 1'b1, 8'h85, 8'h10, 8'h85, 8, Beats, -1, 1'b1);

    // Backpressure for 3 cycles before beat 4.
    send_block({8'h02, 8'hFE, 8'h80, 8'h10}, {8'hFE, 8'h02, 8'h7F, 8'hF0},
               1'b0, 1'b0, 8'h33, 8'h33, 8'h33, 8, Beats, 4, 1'b0);

    // Partial block then reset; the following block must start fresh.
    send_block({8'h01, 8'h7F, 8'h00, 8'h80}, {8'hFF, 8'h81, 8'h00, 8'h7F},
               1'b0, 1'b0, 8'h20, 8'h20, 8'h20, 8, 4, -1, 1'b1);
    rst     = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", {31'h0, o_valid}, 32'd0);
    chk("mid_rst_elements", o_elements, 32'h0);
    chk("mid_rst_scale", {24'h0, o_scale}, 32'h0);
    chk("mid_rst_first", {31'h0, o_first}, 32'd0);
    chk("mid_rst_last", {31'h0, o_last}, 32'd0);
    chk("mid_rst_sat", {26'h0, o_sat_count}, 32'd0);
    chk("mid_rst_in_ready", {31'h0, o_in_ready}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_block({8'h80, 8'h80, 8'h05, 8'h80}, {8'h7F, 8'h7F, 8'hFB, 8'h7F},
               1'b0, 1'b0, 8'h44, 8'h44, 8'h44, 24, Beats, -1, 1'b1);
    i_valid = 1'b0;

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    chk("drain_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mx_negate_stream.md
# mx_negate_stream

Streaming, parametrised successor to the combinational MXINT8 negate. It accepts an MX block (one shared scale plus `BLOCK_SIZE` elements) as a sequence of `LANES`-wide beats over a valid/ready handshake. It negates every element in either integer mode (saturating two's complement) or FP mode (sign flip), and emits the beats one registered stage later with block framing and a per-block saturation count. It sits between the MX block loader and the MX arithmetic pipeline.

## Interface
- `BLOCK_SIZE`, 32, elements per MX block
- `ELEM_WIDTH`, 8, bits per element
- `SCALE_WIDTH`, 8, shared scale width (E8M0)
- `LANES`, 4, elements per beat; must divide `BLOCK_SIZE`
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `i_valid`  in  1  input beat valid
- `o_in_ready`  out  1  input beat accepted when `i_valid & o_in_ready`
- `i_mode`  in  1  0 = INT negate, 1 = FP sign flip; sampled on first beat of block only
- `i_scale`  in  `SCALE_WIDTH`  shared scale; sampled on first beat only
- `i_elements`  in  `[0:LANES-1][ELEM_WIDTH-1:0]`  element beat
- `o_valid`  out  1  output beat valid
- `i_out_ready`  in  1  downstream ready
- `o_scale`  out  `SCALE_WIDTH`  latched block scale, held for all beats of the block
- `o_elements`  out  `[0:LANES-1][ELEM_WIDTH-1:0]`  negated beat
- `o_first`  out  1  beat 0 of block
- `o_last`  out  1  beat `BEATS-1` of block
- `o_sat_count`  out  `$clog2(BLOCK_SIZE+1)`  INT-mode saturations in block; valid only with `o_last`

## Operation
- `BEATS = BLOCK_SIZE/LANES`. The input beat counter `in_beat` (0..BEATS-1) increments on each accepted beat and wraps to 0 after BEATS-1.
- On an accepted beat with `in_beat==0`: latch `i_mode` into `blk_mode` and `i_scale` into `blk_scale`, and clear the saturation accumulator. The first beat uses the incoming `i_mode` directly. Changes on `i_mode` or `i_scale` mid-block are ignored.
- INT mode, per element: out = −x in two's complement. The most-negative value (0x80 for 8 bit) saturates to the most-positive value (0x7F) and increments the accumulator by 1. All lanes are counted in the same cycle, so up to `LANES` can be added per beat.
- FP mode, per element: out = x with the MSB inverted; all other bits are unchanged. 0x00 becomes 0x80, and NaN encodings stay NaN. No saturation is counted.
- Output register stage: one entry. The stage loads when an input beat is accepted. `o_in_ready = ~rst & (~o_valid | i_out_ready)`.
- `o_first`/`o_last` are derived from `in_beat` at acceptance and registered alongside the data. `o_sat_count` is the accumulator value including the last beat's lanes.
- The scale is unchanged by negation.

## Timing
- Reset values: `o_valid`=0, `o_elements`=0, `o_scale`=0, `o_first`=0, `o_last`=0, `o_sat_count`=0, `in_beat`=0, accumulator=0. `o_in_ready`=0 while `rst` is high.
- Latency: the beat accepted in cycle N appears on the outputs in cycle N+1. Throughput is 1 beat/cycle when `i_out_ready` is held high.
- Backpressure: while `o_valid & ~i_out_ready`, all outputs hold stable and `o_in_ready`=0.
- Simultaneous output drain and input accept in the same cycle is legal and gives a bubble-free transfer.
- Reset mid-block discards the partial block. The next accepted beat is treated as beat 0 of a new block.
- `BLOCK_SIZE==LANES` (BEATS=1): every beat asserts both `o_first` and `o_last`.

## Structure
- Shared package `mx_pkg` holds the `BLOCK_SIZE`, `MXINT8_ELEMENT_WIDTH` and scale width defaults, and the mode encoding constants `MX_NEG_INT=1'b0` and `MX_NEG_FP=1'b1`.
- Sub-module `mx_negate_lane` is combinational. It takes element, mode and `ELEM_WIDTH`, returns the negated element and a 1-bit saturation flag, and is instantiated `LANES` times.
- The top level contains the beat counter, block latches, accumulator and output register.

## Test plan
- INT block, LANES=4, BLOCK_SIZE=32, `i_out_ready`=1. Elements 0x01,0x7F,0x00,0x80 repeated. Outputs must be 0xFF,0x81,0x00,0x7F. `o_first` on beat 0 and `o_last` on beat 7. `o_sat_count`=8 on the last beat. Output at cycle N+1.
- FP block with elements 0x00,0x3C,0xBC,0x7F. Outputs must be 0x80,0xBC,0x3C,0xFF. `o_sat_count`=0.
- Mode/scale stability: `i_scale`=0x85 and mode INT on beat 0, then `i_scale`=0x10 and mode FP from beat 1. `o_scale` must be 0x85 and INT negation must apply for all 8 beats.
- Backpressure: drop `i_out_ready` for 3 cycles mid-block. Outputs hold, `o_in_ready`=0, no beat is lost or duplicated, and beat order and `o_last` position are unchanged.
- Reset after beat 3 of a block. All outputs return to zero the cycle after reset is applied. The next accepted beat produces `o_first`=1, and `o_sat_count` counts only the new block.
- Two back-to-back blocks with `i_valid` and `i_out_ready` held high: 16 consecutive output beats with no bubble, and the accumulator resets between blocks.
